// File: rtl/serial_comp_pkg.sv
// Purpose: shared types and constants for the serial 2's-complement sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default parameter values, counter-width helper.
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_DEB_CYCLES  = 1000000;   // 10 ms at 100 MHz
    localparam int DEF_STEP_CYCLES = 50000000;  // 0.5 s at 100 MHz

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/serial_comp_sequencer_if.sv
// Purpose: command bus between the sequencer and the serial 2's-complement shifter.
// Latency: n/a (wires only).
// Backpressure: none; the shifter consumes every strobe.
// Signals: start_btn/step_mode (user inputs), load/clr_state/ctrl (shifter commands),
//          busy/done/bit_cnt (status). master = sequencer, slave = shifter/observer side.
interface serial_comp_sequencer_if
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                      start_btn;
    logic                      step_mode;
    logic                      load;
    logic                      clr_state;
    logic                      ctrl;
    logic                      busy;
    logic                      done;
    logic [cnt_w(WIDTH)-1:0]   bit_cnt;

    modport master (
        input  start_btn, step_mode,
        output load, clr_state, ctrl, busy, done, bit_cnt
    );

    modport slave (
        output start_btn, step_mode,
        input  load, clr_state, ctrl, busy, done, bit_cnt
    );
endinterface

// File: rtl/btn_debounce.sv
// Purpose: synchronize and debounce a raw push-button, emit a pulse on each accepted press.
// Latency: rise_pulse 2+DEB_CYCLES clocks after the button settles high.
// Backpressure: none; the pulse is a single-cycle strobe.
// Ports: clk, rst_n (sync, active-low), btn_raw (async), level (debounced), rise_pulse.
module btn_debounce
    import serial_comp_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
)(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);
    localparam int            CW       = cnt_w(DEB_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            // Count consecutive clocks where the synchronized input disagrees
            // with the accepted level; any agreement (a bounce) restarts it.
            if (sync2 != level) begin
                if (cnt == DEB_LAST) begin
                    level      <= sync2;
                    rise_pulse <= sync2;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/serial_comp_sequencer.sv
// Purpose: turn a button press into load + WIDTH ctrl cycles for the serial shifter, then hold done.
// Latency: load 1 clock after start_pulse; ctrl every clock (step_mode=0) or every STEP_CYCLES clocks.
// Backpressure: none; presses arriving while busy are dropped, not queued.
// Ports: clk, rst_n (sync, active-low), bus (master modport: start_btn, step_mode in;
//        load, clr_state, ctrl, busy, done, bit_cnt out).
module serial_comp_sequencer
    import serial_comp_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES
)(
    input  logic                    clk,
    input  logic                    rst_n,
    serial_comp_sequencer_if.master bus
);
    localparam int            BW        = cnt_w(WIDTH);
    localparam int            TW        = cnt_w(STEP_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [BW-1:0] bit_cnt_q;
    logic [TW-1:0] tick_q;
    logic          mode_q;
    logic          start_pulse;
    logic          btn_level;
    logic          start_go;
    logic          ctrl_c;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (bus.start_btn),
        .level      (btn_level),
        .rise_pulse (start_pulse)
    );

    // The pulse is raised together with the level, so this is a qualified strobe.
    assign start_go = start_pulse & btn_level;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ctrl_c    = 1'b0;
        unique case (state)
            IDLE:  if (start_go) state_nxt = LOAD;
            LOAD:  state_nxt = SHIFT;
            SHIFT: begin
                // mode_q is frozen at LOAD, so step_mode changes land next conversion.
                ctrl_c = !mode_q || (tick_q == TICK_LAST);
                if (ctrl_c && bit_cnt_q == BIT_LAST) state_nxt = DONE;
            end
            DONE:  if (start_go) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            tick_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    bit_cnt_q <= '0;
                    tick_q    <= '0;
                    mode_q    <= bus.step_mode;
                end
                SHIFT: begin
                    if (ctrl_c) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        tick_q    <= '0;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.load      = (state == LOAD);
    assign bus.clr_state = (state == LOAD);
    assign bus.ctrl      = ctrl_c;
    assign bus.busy      = (state == LOAD) || (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_serial_comp_sequencer.sv
// Purpose: self-checking bench for serial_comp_sequencer with a behavioural timing model
//          and a behavioural serial 2's-complement shifter on the command outputs.
// Latency/backpressure: n/a.
module tb_serial_comp_sequencer;
    localparam int W    = 4;
    localparam int DEB  = 4;
    localparam int STEP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    serial_comp_sequencer_if #(.WIDTH(W)) bus ();

    serial_comp_sequencer #(.WIDTH(W), .DEB_CYCLES(DEB), .STEP_CYCLES(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Downstream shifter: LSB-first, output bit = in ^ seen_one, result rotated in at MSB.
    logic [3:0] x_in;
    logic [3:0] sh_reg;
    logic       sh_c;
    always @(posedge clk) begin
        if (bus.load) sh_reg <= x_in;
        else if (bus.ctrl) begin
            sh_reg <= {sh_reg[0] ^ sh_c, sh_reg[3:1]};
            sh_c   <= sh_c | sh_reg[0];
        end
        if (bus.clr_state) sh_c <= 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input int exp_done);
        chk({tag, "_load"}, bus.load, 0);
        chk({tag, "_clr"},  bus.clr_state, 0);
        chk({tag, "_ctrl"}, bus.ctrl, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, exp_done);
        chk({tag, "_bcnt"}, bus.bit_cnt, (exp_done != 0) ? W : 0);
    endtask

    // Bounded wait for load; returns clocks waited.
    task automatic wait_load(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.load && n < 40);
        chk("load_seen", bus.load, 1);
    endtask

    // Press from IDLE/DONE; button must be debounced low beforehand.
    task automatic press(input bit mode, input logic [3:0] x);
        int n;
        bus.step_mode = mode;
        x_in          = x;
        bus.start_btn = 1'b1;
        wait_load(n);
        chk("press_to_load", n, 2 + DEB + 1);
        bus.start_btn = 1'b0;
    endtask

    // Called in the load cycle; checks every following cycle against the timing model.
    task automatic run_conv(input bit mode, input int press_at, input int press_len, input bit wiggle);
        int s, c, nctrl, e_ctrl, e_done, e_bit;
        s     = mode ? STEP : 1;
        nctrl = 0;
        chk("L_load", bus.load, 1);
        chk("L_clr",  bus.clr_state, 1);
        chk("L_ctrl", bus.ctrl, 0);
        chk("L_busy", bus.busy, 1);
        chk("L_done", bus.done, 0);
        for (c = 1; c <= W * s + 2; c++) begin
            tick();
            if (c == press_at)             bus.start_btn = 1'b1;
            if (c == press_at + press_len) bus.start_btn = 1'b0;
            if (wiggle)                    bus.step_mode = 1'($urandom);
            e_ctrl = ((c % s) == 0 && c / s >= 1 && c / s <= W) ? 1 : 0;
            e_done = (c > W * s) ? 1 : 0;
            e_bit  = ((c - 1) / s > W) ? W : (c - 1) / s;
            nctrl += bus.ctrl ? 1 : 0;
            chk($sformatf("c%0d_ctrl", c), bus.ctrl, e_ctrl);
            chk($sformatf("c%0d_done", c), bus.done, e_done);
            chk($sformatf("c%0d_busy", c), bus.busy, 1 - e_done);
            chk($sformatf("c%0d_load", c), bus.load, 0);
            chk($sformatf("c%0d_bcnt", c), bus.bit_cnt, e_bit);
        end
        chk("ctrl_count", nctrl, W);
        chk("shifter_neg", sh_reg, (16 - int'(x_in)) % 16);
    endtask

    initial begin
        int n;
        bus.start_btn = 1'b0;
        bus.step_mode = 1'b0;
        x_in          = 4'd0;
        rst_n         = 1'b0;
        repeat (2) tick();
        chk_quiet("rst0", 0);
        rst_n = 1'b1;

        // Bounces shorter than the debounce window never start a conversion.
        repeat (3) begin
            bus.start_btn = 1'b1;
            repeat (3) begin tick(); chk_quiet("bounce_hi", 0); end
            bus.start_btn = 1'b0;
            repeat (3) begin tick(); chk_quiet("bounce_lo", 0); end
        end
        repeat (6) begin tick(); chk_quiet("bounce_tail", 0); end

        // Button held through reset: one pulse, load 7 clocks after release.
        rst_n         = 1'b0;
        bus.start_btn = 1'b1;
        x_in          = 4'b0101;
        repeat (2) begin tick(); chk_quiet("rst_held", 0); end
        rst_n = 1'b1;
        wait_load(n);
        chk("held_rst_to_load", n, 7);
        bus.start_btn = 1'b0;
        run_conv(1'b0, -1, 0, 1'b0);
        chk("e2e_y", sh_reg, 4'b1011);

        // Step mode with step_mode wiggling mid-conversion.
        repeat (3) tick();
        press(1'b1, 4'b0011);
        run_conv(1'b1, -1, 0, 1'b1);

        // Press during SHIFT is dropped; done then holds.
        repeat (2) tick();
        press(1'b1, 4'b1000);
        run_conv(1'b1, 5, 6, 1'b0);
        repeat (10) begin tick(); chk_quiet("no_queue", 1); end

        // Press from DONE starts a fresh conversion (done low in load cycle).
        press(1'b0, 4'b0110);
        run_conv(1'b0, -1, 0, 1'b0);

        // Randomized conversions.
        for (int i = 0; i < 6; i++) begin
            repeat (2 + $urandom_range(0, 3)) begin tick(); chk_quiet("gap", 1); end
            press(1'($urandom), 4'($urandom));
            run_conv(bus.step_mode, -1, 0, 1'b1);
        end

        // Reset after the second ctrl aborts immediately.
        repeat (3) tick();
        press(1'b0, 4'b0111);
        tick();
        tick();
        chk("pre_rst_ctrl", bus.ctrl, 1);
        chk("pre_rst_bcnt", bus.bit_cnt, 1);
        rst_n = 1'b0;
        tick();
        chk_quiet("mid_rst", 0);
        rst_n = 1'b1;
        repeat (12) begin tick(); chk_quiet("post_rst", 0); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
